// File: rtl/img_pkg.sv
// img_pkg: shared FSM state type, error bit indices and default coordinate width
// for the pixel coordinate front end.
package img_pkg;

    localparam int unsigned COORD_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LN,
        ACTIVE,
        DONE
    } fsm_state_t;

    localparam int unsigned ERR_SHORT = 0;
    localparam int unsigned ERR_LONG  = 1;
    localparam int unsigned ERR_FRAME = 2;
    localparam int unsigned ERR_W     = 3;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered single-bit edge detector. RISING=1 pulses on a 0->1
// transition, RISING=0 on a 1->0 transition; the pulse is same-cycle with the input.
module edge_detect #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign pulse = RISING ? (sig & ~sig_d) : (~sig & sig_d);

endmodule

// File: rtl/pixel_coord_gen.sv
// pixel_coord_gen: tags a de/vsync pixel stream with x/y and sof/eol/eof markers,
// two-cycle latency. Sticky geometry error flags are built only with FRAME_CHECK_EN.
module pixel_coord_gen
    import img_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned COORD_W    = COORD_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  de,
    input  logic                  vsync,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [COORD_W-1:0]    x,
    output logic [COORD_W-1:0]    y,
    output logic                  pix_valid,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic [2:0]            err
);

    localparam logic [COORD_W-1:0] X_END  = COORD_W'(IMG_WIDTH);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    logic                  vsync_rise;
    logic                  de_fall;
    fsm_state_t            state, state_n;
    logic [COORD_W-1:0]    x_cnt, x_cnt_n;
    logic [COORD_W-1:0]    y_cnt, y_cnt_n;
    logic                  cap_valid;
    logic [ERR_W-1:0]      err_set;
    logic [DATA_WIDTH-1:0] s1_pix;
    logic [COORD_W-1:0]    s1_x;
    logic [COORD_W-1:0]    s1_y;
    logic                  s1_valid;
    logic                  line_end;

    edge_detect #(.RISING(1'b1)) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vsync),
        .pulse (vsync_rise)
    );

    edge_detect #(.RISING(1'b0)) u_de_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (de),
        .pulse (de_fall)
    );

    // x_cnt is the column the next de pixel will take; it parks at IMG_WIDTH on long lines.
    always_comb begin
        state_n   = state;
        x_cnt_n   = x_cnt;
        y_cnt_n   = y_cnt;
        cap_valid = 1'b0;
        err_set   = '0;
        if (vsync_rise) begin
            state_n = WAIT_LN;
            x_cnt_n = '0;
            y_cnt_n = '0;
            if ((state == ACTIVE || state == WAIT_LN) && y_cnt != '0) begin
                err_set[ERR_FRAME] = 1'b1;
            end
        end else begin
            case (state)
                WAIT_LN, ACTIVE: begin
                    if (de) begin
                        state_n = ACTIVE;
                        if (x_cnt < X_END) begin
                            cap_valid = 1'b1;
                            x_cnt_n   = x_cnt + COORD_W'(1);
                        end else begin
                            err_set[ERR_LONG] = 1'b1;
                        end
                    end else if (state == ACTIVE && de_fall) begin
                        x_cnt_n = '0;
                        y_cnt_n = y_cnt + COORD_W'(1);
                        if (x_cnt < X_END) begin
                            err_set[ERR_SHORT] = 1'b1;
                        end
                        state_n = (y_cnt == Y_LAST) ? DONE : WAIT_LN;
                    end
                end
                DONE: begin
                    if (de) begin
                        err_set[ERR_FRAME] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            state    <= state_n;
            x_cnt    <= x_cnt_n;
            y_cnt    <= y_cnt_n;
            s1_valid <= cap_valid;
            if (cap_valid) begin
                s1_pix <= pixel_in;
                s1_x   <= x_cnt;
                s1_y   <= y_cnt;
            end
        end
    end

    // The captured pixel ends its line if de has dropped by now or it sits in the last column.
    assign line_end = s1_valid & (de_fall | (s1_x == X_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            x         <= '0;
            y         <= '0;
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            pix_valid <= s1_valid;
            sof       <= s1_valid && s1_x == '0 && s1_y == '0;
            eol       <= line_end;
            eof       <= line_end && s1_y == Y_LAST;
            if (s1_valid) begin
                pixel_out <= s1_pix;
                x         <= s1_x;
                y         <= s1_y;
            end
        end
    end

`ifdef FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= (err & {ERR_W{~err_clr}}) | err_set;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{err_clr, err_set};
    assign err        = '0;
`endif

endmodule

// File: tb/tb_pixel_coord_gen.sv
// tb_pixel_coord_gen: randomized line/frame stimulus against a line-level reference
// model; expected tagged pixels are queued and matched by a stream monitor.
module tb_pixel_coord_gen;

    localparam int DW = 8;
    localparam int W  = 31;
    localparam int H  = 9;
    localparam int CW = 5;
`ifdef FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic          de = 1'b0;
    logic          vsync = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] pixel_out;
    logic [CW-1:0] x, y;
    logic          pix_valid, sof, eol, eof;
    logic [2:0]    err;

    pixel_coord_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COORD_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixel_in  (pixel_in),
        .de        (de),
        .vsync     (vsync),
        .err_clr   (err_clr),
        .pixel_out (pixel_out),
        .x         (x),
        .y         (y),
        .pix_valid (pix_valid),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pix;
        int            x;
        int            y;
        bit            sof;
        bit            eol;
        bit            eof;
        int            cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0;
    bit         m_armed = 1'b0;
    int         m_line = 0;
    logic [2:0] m_err = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] exp_err();
        return FC ? m_err : 3'b000;
    endfunction

    // Stream monitor: every tagged pixel must match the next expected one, 2 cycles after drive.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                n_valid++;
                if (sof) n_sof++;
                if (eol) n_eol++;
                if (eof) n_eof++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL stream_extra: got pixel x=%0d y=%0d, required none", x, y);
                end else begin
                    e = exp_q.pop_front();
                    if ({pixel_out, x, y, sof, eol, eof} !== {e.pix, CW'(e.x), CW'(e.y), e.sof, e.eol, e.eof}
                        || cyc != e.cyc + 2) begin
                        n_errors++;
                        $display("FAIL stream: got pix=%h x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d, required pix=%h x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d",
                                 pixel_out, x, y, sof, eol, eof, cyc, e.pix, e.x, e.y, e.sof, e.eol, e.eof, e.cyc + 2);
                    end
                end
            end else begin
                n_checks++;
                if ({sof, eol, eof} !== 3'b000) begin
                    n_errors++;
                    $display("FAIL markers_unqualified: got sof/eol/eof=%b without pix_valid, required 000", {sof, eol, eof});
                end
            end
        end
    end

    task automatic push_exp(input logic [DW-1:0] pix, input int px, input int row, input bit last);
        exp_t t;
        t.pix = pix;
        t.x   = px;
        t.y   = row;
        t.sof = (px == 0 && row == 0);
        t.eol = last;
        t.eof = last && row == H - 1;
        t.cyc = cyc;
        exp_q.push_back(t);
    endtask

    // One de burst of len pixels then blank idle cycles; tagging follows the frame model.
    task automatic send_line(input int len, input int blank, input bit clr_first);
        int row;
        int tag;
        row = (m_armed && m_line < H) ? m_line : -1;
        tag = (len < W) ? len : W;
        if (clr_first) m_err = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            de       = 1'b1;
            pixel_in = DW'($urandom);
            err_clr  = clr_first && i == 0;
            if (row >= 0 && i < tag) push_exp(pixel_in, i, row, i == tag - 1);
        end
        for (int i = 0; i < blank; i++) begin
            @(negedge clk);
            de      = 1'b0;
            err_clr = 1'b0;
        end
        if (m_armed) begin
            if (m_line >= H) m_err[2] = 1'b1;
            else begin
                if (len < W) m_err[0] = 1'b1;
                if (len > W) m_err[1] = 1'b1;
            end
            m_line++;
        end
    endtask

    task automatic send_vsync(input int hi);
        if (m_armed && m_line > 0 && m_line < H) m_err[2] = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            vsync = 1'b1;
            de    = 1'b0;
        end
        @(negedge clk);
        vsync   = 1'b0;
        m_armed = 1'b1;
        m_line  = 0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        de      = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pixel_out !== '0) begin n_errors++; $display("FAIL reset_pixel_out: got %h, required 0", pixel_out); end
        n_checks++; if (x !== '0) begin n_errors++; $display("FAIL reset_x: got %0d, required 0", x); end
        n_checks++; if (y !== '0) begin n_errors++; $display("FAIL reset_y: got %0d, required 0", y); end
        n_checks++; if (pix_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pix_valid: got %b, required 0", pix_valid); end
        n_checks++; if ({sof, eol, eof} !== 3'b000) begin n_errors++; $display("FAIL reset_markers: got %b, required 000", {sof, eol, eof}); end
        n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL reset_err: got %b, required 000", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_no_lock();
        int v0;
        v0 = n_valid;
        for (int p = 0; p < 4; p++) send_line(1 + $urandom_range(0, W), 2, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_valid != v0) begin n_errors++; $display("FAIL no_lock: got %0d tagged pixels before vsync, required 0", n_valid - v0); end
        send_vsync(2);
        for (int l = 0; l < H; l++) send_line(W, $urandom_range(1, 4), 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL no_lock_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_full_frame();
        int v0, s0, l0, f0;
        v0 = n_valid; s0 = n_sof; l0 = n_eol; f0 = n_eof;
        send_vsync(3);
        for (int l = 0; l < H; l++) send_line(W, $urandom_range(1, 6), 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (n_valid - v0 != W * H) begin n_errors++; $display("FAIL frame_valid: got %0d, required %0d", n_valid - v0, W * H); end
        n_checks++; if (n_sof - s0 != 1) begin n_errors++; $display("FAIL frame_sof: got %0d, required 1", n_sof - s0); end
        n_checks++; if (n_eol - l0 != H) begin n_errors++; $display("FAIL frame_eol: got %0d, required %0d", n_eol - l0, H); end
        n_checks++; if (n_eof - f0 != 1) begin n_errors++; $display("FAIL frame_eof: got %0d, required 1", n_eof - f0); end
        n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL frame_err: got %b, required 000", err); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL frame_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_short_line();
        send_vsync(1);
        for (int l = 0; l < H; l++) send_line((l == 5) ? $urandom_range(1, W - 1) : W, 2, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL short_err: got %b, required %b", err, exp_err()); end
        pulse_clr();
        @(negedge clk);
        n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL short_clr: got %b, required 000", err); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL short_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_long_line();
        send_vsync(1);
        for (int l = 0; l < H; l++) send_line((l == 2) ? $urandom_range(W + 1, W + 9) : W, 3, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL long_err: got %b, required %b", err, exp_err()); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL long_drain: got %0d pending, required 0", exp_q.size()); end
        pulse_clr();
    endtask

    task automatic test_vsync_abort();
        int k, r, s0;
        s0 = n_sof;
        send_vsync(1);
        for (int l = 0; l < 7; l++) send_line(W, 2, 1'b0);
        k = $urandom_range(1, W - 2);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            de = 1'b1;
            pixel_in = DW'($urandom);
            push_exp(pixel_in, i, m_line, 1'b0);
        end
        @(negedge clk);
        vsync    = 1'b1;
        pixel_in = DW'($urandom);
        if (m_line > 0) m_err[2] = 1'b1;
        m_line = 0;
        r = W;
        for (int i = 0; i < r; i++) begin
            @(negedge clk);
            vsync    = 1'b0;
            pixel_in = DW'($urandom);
            push_exp(pixel_in, i, 0, i == r - 1);
        end
        @(negedge clk);
        de = 1'b0;
        m_line = 1;
        for (int l = 1; l < H; l++) send_line(W, 2, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (n_sof - s0 != 2) begin n_errors++; $display("FAIL abort_sof: got %0d, required 2", n_sof - s0); end
        n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL abort_err: got %b, required %b", err, exp_err()); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL abort_drain: got %0d pending, required 0", exp_q.size()); end
        pulse_clr();
    endtask

    task automatic test_extra_line();
        int v0;
        v0 = n_valid;
        send_vsync(2);
        for (int l = 0; l < H; l++) send_line(W, 2, 1'b0);
        send_line(W, 3, 1'b0);
        n_checks++; if (n_valid - v0 != W * H) begin n_errors++; $display("FAIL extra_valid: got %0d, required %0d", n_valid - v0, W * H); end
        n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL extra_err: got %b, required %b", err, exp_err()); end
        pulse_clr();
        @(negedge clk);
        n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL extra_clr: got %b, required 000", err); end
        // clear and a DONE-state de pixel in the same cycle: the set must survive
        send_line(1, 3, 1'b1);
        n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL set_wins: got %b, required %b", err, exp_err()); end
        pulse_clr();
    endtask

    task automatic test_random_frames();
        int len;
        for (int f = 0; f < 4; f++) begin
            send_vsync($urandom_range(1, 3));
            for (int l = 0; l < H; l++) begin
                len = ($urandom_range(0, 9) < 6) ? W : $urandom_range(1, W + 8);
                send_line(len, $urandom_range(1, 5), 1'b0);
            end
            if ($urandom_range(0, 3) == 0) send_line($urandom_range(1, W), 2, 1'b0);
            repeat (2) @(negedge clk);
            n_checks++; if (err !== exp_err()) begin n_errors++; $display("FAIL rand_err[%0d]: got %b, required %b", f, err, exp_err()); end
            n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_drain[%0d]: got %0d pending, required 0", f, exp_q.size()); end
            pulse_clr();
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        send_vsync(1);
        send_line(W, 2, 1'b0);
        send_line(W - 3, 2, 1'b0);
        @(negedge clk);
        de = 1'b1;
        pixel_in = DW'($urandom);
        @(negedge clk);
        rst_n = 1'b0;
        de    = 1'b0;
        #1;
        n_checks++;
        if ({pixel_out, x, y, pix_valid, sof, eol, eof, err} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got pix=%h x=%0d y=%0d v=%b markers=%b err=%b, required all 0",
                     pixel_out, x, y, pix_valid, {sof, eol, eof}, err);
        end
        exp_q.delete();
        m_armed = 1'b0;
        m_line  = 0;
        m_err   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        send_line(W, 3, 1'b0);
        n_checks++;
        if (n_valid != v0) begin n_errors++; $display("FAIL midreset_relock: got %0d tagged pixels, required 0", n_valid - v0); end
        send_vsync(1);
        for (int l = 0; l < H; l++) send_line(W, 2, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++; if (err !== 3'b000) begin n_errors++; $display("FAIL midreset_err: got %b, required 000", err); end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_no_lock();
        test_full_frame();
        test_short_line();
        test_long_line();
        test_vsync_abort();
        test_extra_line();
        test_random_frames();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
